// File: rtl/branch_resolve_unit_if.sv
// Purpose : request/result bundle between decode/regfile read, the branch
//           resolve stage and the PC-select mux.
// Ports   : in_* request side (valid/ready), out_* result side (valid/ready).
//           master = producer/consumer environment, slave = resolve unit.
interface branch_resolve_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_mispredict;
  logic            out_illegal;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_mispredict, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Purpose : resolves RV64 branch conditions, next PC and misprediction, with
//           saturating branch / mispredict statistics counters.
// Latency : result on out_* one cycle after acceptance; one result per cycle.
// Backpr. : in_ready = empty | out_ready; a held result stays stable while !out_ready.
// Ports   : clk, rst_n (async, active low); bus (slave modport: in_* request,
//           out_* result); cnt_clear (sync clear); branch_count, mispredict_count.
module branch_resolve_unit #(
  parameter int XLEN    = 64,
  parameter int CNT_W   = 32,
  parameter int PC_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     branch_count,
  output logic [CNT_W-1:0]     mispredict_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  logic            accept;
  logic            legal;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] target;

  logic            taken_q;
  logic            mispredict_q;
  logic            illegal_q;
  logic [XLEN-1:0] target_q;

  // A full stage can still take a new request in the same cycle its result drains.
  assign bus.in_ready = (state == EMPTY) | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (bus.in_funct3)
      3'b000:  taken = (bus.in_rs1 == bus.in_rs2);
      3'b001:  taken = (bus.in_rs1 != bus.in_rs2);
      3'b100:  taken = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
      3'b101:  taken = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
      3'b110:  taken = (bus.in_rs1 <  bus.in_rs2);
      3'b111:  taken = (bus.in_rs1 >= bus.in_rs2);
      default: legal = 1'b0;
    endcase
  end

  // Additions wrap modulo 2^XLEN by construction; an illegal code is never taken,
  // so it falls through to pc + PC_STEP.
  assign target     = taken ? (bus.in_pc + bus.in_imm) : (bus.in_pc + XLEN'(PC_STEP));
  assign mispredict = legal & (taken ^ bus.in_pred_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (bus.out_ready && !bus.in_valid) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      // Result registers only move on acceptance, which keeps a stalled result stable.
      if (accept) begin
        taken_q      <= taken;
        mispredict_q <= mispredict;
        illegal_q    <= ~legal;
        target_q     <= target;
      end
    end
  end

  assign bus.out_valid      = (state == FULL);
  assign bus.out_taken      = taken_q;
  assign bus.out_mispredict = mispredict_q;
  assign bus.out_illegal    = illegal_q;
  assign bus.out_target     = target_q;

  // Counting on acceptance (not on output) means a held result is counted once.
  // Clear takes priority over a concurrent acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (cnt_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (accept) begin
      if (legal && (branch_count != CNT_MAX))
        branch_count <= branch_count + CNT_W'(1);
      if (mispredict && (mispredict_count != CNT_MAX))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule
